// File: rtl/uart_rx_deframer_if.sv
// Byte-side and line-side signal bundle of the UART receive deframer.
// master: the deframer (drives byte/status), slave: line source + byte consumer.
//   serialIn    raw UART line, idle high, LSB first
//   rx_ack      consumer accepts rx_data this cycle
//   rx_data     last good received byte
//   rx_valid    rx_data holds an unconsumed byte
//   rx_busy     frame reception in progress
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun_err one-cycle pulse, byte overwritten before ack
//   parity_err  one-cycle pulse, parity mismatch (parity build only)
interface uart_rx_deframer_if;
    logic       serialIn;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    modport master (
        input  serialIn,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun_err,
        output parity_err
    );

    modport slave (
        output serialIn,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronises serialIn, validates the start bit,
// samples each bit at mid-bit, checks the stop bit and hands bytes over with
// a valid/ack level handshake plus framing and overrun pulses.
// Ports: sysclk (clock), reset (async, active high), bus (uart_rx_deframer_if.master).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (8E1) and enable parity_err.
module uart_rx_deframer #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_rx_deframer_if.master bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;

    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;
    logic             r_perr;

    logic             w_busy;
    logic             w_bit_end;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_stop_smp;
    logic             w_good_stop;
    logic             w_bad_stop;
    logic             w_par_bad;
    logic             w_load;

`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             w_par_smp;
`endif

    // ------------------------------------------------------------
    // Two-flop synchroniser, preset to the idle (high) line level
    // ------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.serialIn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next = S_START;
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch
                if (w_bit_end) w_next = w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_next = w_rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                // Held-low line: wait for idle so only one frame_err is raised
                if (w_rxs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------
    always_comb begin
        w_busy     = 1'b1;
        w_bit_end  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_stop_smp = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy    = 1'b0;
                w_cnt_clr = 1'b1;
            end
            S_START: begin
                w_bit_end = (r_cnt == HALF_LAST);
                w_cnt_clr = w_bit_end;
            end
            S_DATA: begin
                w_bit_end  = (r_cnt == FULL_LAST);
                w_cnt_clr  = w_bit_end;
                w_shift_en = w_bit_end;
            end
            S_PARITY: begin
                w_bit_end = (r_cnt == FULL_LAST);
                w_cnt_clr = w_bit_end;
            end
            S_STOP: begin
                w_bit_end  = (r_cnt == FULL_LAST);
                w_cnt_clr  = w_bit_end;
                w_stop_smp = w_bit_end;
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
            end
            default: begin
                w_busy    = 1'b0;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_smp = (r_state == S_PARITY) && w_bit_end;
    // Even parity: data bits plus parity bit must hold an even count of ones
    assign w_par_bad = (^r_shift) ^ r_par;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_good_stop = w_stop_smp && w_rxs;
    assign w_bad_stop  = w_stop_smp && !w_rxs;
    assign w_load      = w_good_stop && !w_par_bad;

    // ------------------------------------------------------------
    // Bit timing counter, bit index and shift register
    // ------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_idx <= 3'd0;
        end else if (r_state != S_DATA) begin
            r_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // LSB arrives first, so shifting right leaves bit 0 in r_shift[0]
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_shift <= 8'h00;
        end else if (w_shift_en) begin
            r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (w_par_smp) begin
            r_par <= w_rxs;
        end
    end
`endif

    // ------------------------------------------------------------
    // Byte handover and error pulses
    // ------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_load) begin
            // A new byte wins over a same-cycle ack: valid stays set
            r_data  <= r_shift;
            r_valid <= 1'b1;
        end else if (bus.rx_ack && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_ferr <= w_bad_stop;
            r_ovr  <= w_load && r_valid && !bus.rx_ack;
            r_perr <= w_stop_smp && w_par_bad;
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.rx_busy     = w_busy;
    assign bus.frame_err   = r_ferr;
    assign bus.overrun_err = r_ovr;
    assign bus.parity_err  = r_perr;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer with a byte scoreboard queue.
// Runs at 16 clocks per bit so every scenario fits a short simulation.
module tb_uart_rx_deframer;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // sync (2) + IDLE detect (1) + half start bit + data/parity/stop bits
    localparam int LAT = 3 + CPB / 2 + NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_deframer_if bus();

    uart_rx_deframer #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .sysclk(clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_perr  = 0;
    int n_vrise = 0;
    int t_vrise = 0;
    int t_start = 0;
    logic prev_v = 1'b0;

    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_err)   n_ferr++;
            if (bus.overrun_err) n_ovr++;
            if (bus.parity_err)  n_perr++;
            if (bus.rx_valid && !prev_v) begin
                n_vrise++;
                t_vrise = cyc;
            end
        end
        prev_v = bus.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        if (!bad_par) exp_q.push_back(b);
        t_start = cyc;
        bus.serialIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.serialIn = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.serialIn = (^b) ^ bad_par;
        repeat (CPB) @(negedge clk);
`endif
        bus.serialIn = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(bus.rx_data), 32'(e));
            chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        end
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    initial begin
        int f0;
        int o0;
        int p0;
        int v0;
        logic [7:0] rb;

        bus.serialIn = 1'b1;
        bus.rx_ack   = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_data",  32'(bus.rx_data),     32'h0);
        chk("rst_valid", 32'(bus.rx_valid),    32'h0);
        chk("rst_busy",  32'(bus.rx_busy),     32'h0);
        chk("rst_ferr",  32'(bus.frame_err),   32'h0);
        chk("rst_ovr",   32'(bus.overrun_err), 32'h0);
        chk("rst_perr",  32'(bus.parity_err),  32'h0);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        chk("idle_valid", 32'(bus.rx_valid), 32'h0);
        chk("idle_busy",  32'(bus.rx_busy),  32'h0);

        // Ack with nothing pending is ignored
        ack_pulse();
        chk("stray_ack_valid", 32'(bus.rx_valid), 32'h0);

        // Single frame 0x55, latency, then ack
        f0 = n_ferr;
        o0 = n_ovr;
        send_frame(8'h55, 1'b0);
        check_rx("b55");
        chk("b55_latency", 32'(t_vrise - t_start), 32'(LAT));
        chk("b55_no_ferr", 32'(n_ferr - f0), 32'd0);
        ack_pulse();
        chk("b55_ack_clear", 32'(bus.rx_valid), 32'h0);

        // Back-to-back 0xAA, 0x08 with no ack: one overrun
        o0 = n_ovr;
        send_frame(8'hAA, 1'b0);
        check_rx("bAA");
        send_frame(8'h08, 1'b0);
        check_rx("b08_ovr");
        chk("ovr_count", 32'(n_ovr - o0), 32'd1);
        ack_pulse();
        chk("ovr_ack_clear", 32'(bus.rx_valid), 32'h0);

        // Same pair with ack landing on the second stop sample
        o0 = n_ovr;
        send_frame(8'hAA, 1'b0);
        check_rx("bAA2");
        fork
            send_frame(8'h08, 1'b0);
            begin
                repeat (LAT - 1) @(negedge clk);
                ack_pulse();
            end
        join
        check_rx("b08_ack");
        chk("no_ovr_count", 32'(n_ovr - o0), 32'd0);
        ack_pulse();
        chk("ack2_clear", 32'(bus.rx_valid), 32'h0);

        // Short low glitch on an idle line
        f0 = n_ferr;
        v0 = n_vrise;
        bus.serialIn = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        bus.serialIn = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_busy",  32'(bus.rx_busy),    32'h0);
        chk("glitch_vrise", 32'(n_vrise - v0),   32'd0);
        chk("glitch_ferr",  32'(n_ferr - f0),    32'd0);

        // Line held low: a single frame_err, busy until the line recovers
        f0 = n_ferr;
        v0 = n_vrise;
        bus.serialIn = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        chk("brk_busy_mid", 32'(bus.rx_busy), 32'h1);
        repeat (20 * CPB) @(negedge clk);
        chk("brk_busy_end", 32'(bus.rx_busy),  32'h1);
        chk("brk_ferr",     32'(n_ferr - f0),  32'd1);
        chk("brk_data",     32'(bus.rx_data),  32'h08);
        chk("brk_vrise",    32'(n_vrise - v0), 32'd0);
        bus.serialIn = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("brk_busy_idle", 32'(bus.rx_busy), 32'h0);

        // Reset during data bit 4, then a clean 0x55
        f0 = n_ferr;
        o0 = n_ovr;
        p0 = n_perr;
        rb = 8'h33;
        bus.serialIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.serialIn = rb[i];
            repeat (CPB) @(negedge clk);
        end
        bus.serialIn = rb[4];
        repeat (CPB / 2) @(negedge clk);
        chk("mid_busy", 32'(bus.rx_busy), 32'h1);
        rst = 1'b1;
        bus.serialIn = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
        chk("mid_rst_data", 32'(bus.rx_data), 32'h0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        v0 = n_vrise;
        send_frame(8'h55, 1'b0);
        check_rx("post_rst_b55");
        chk("post_rst_vrise", 32'(n_vrise - v0), 32'd1);
        chk("post_rst_errs",
            32'((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)), 32'd0);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        p0 = n_perr;
        v0 = n_vrise;
        send_frame(8'h55, 1'b0);
        check_rx("par_good");
        chk("par_good_perr", 32'(n_perr - p0), 32'd0);
        ack_pulse();
        v0 = n_vrise;
        send_frame(8'h55, 1'b1);
        chk("par_bad_perr",  32'(n_perr - p0),   32'd1);
        chk("par_bad_vrise", 32'(n_vrise - v0),  32'd0);
        chk("par_bad_valid", 32'(bus.rx_valid),  32'h0);
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial front end of the tweetboard datapath: converts the asynchronous 8N1 `serialIn` line into bytes for the character buffer stage downstream.
- Synchronises the line, validates the start bit, samples at mid-bit, checks the stop bit.
- Presents each byte with a valid/ack handshake, plus framing and overrun error reporting.

Parameters:
- CLK_FREQ, 50000000, sysclk frequency in Hz
- BAUD, 9600, line bit rate
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), sysclk cycles per bit; counter width = $clog2(CLKS_PER_BIT)

Ports:
- sysclk  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-high reset
- serialIn  input  1  raw UART line, idle high, LSB first
- rx_ack  input  1  consumer accepts rx_data this cycle
- rx_data  output  8  last good received byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_busy  output  1  frame reception in progress
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: byte overwritten before ack
- parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset (async, active high): all outputs 0, state IDLE, counters 0, synchroniser flops set to 1 (idle line).
- serialIn passes through 2 flops; all decisions use the synchronised bit `rxs`. Input-to-decision latency is 2 cycles.
- IDLE: rx_busy=0. When rxs=0, clear the counter and go to START.
- START: count CLKS_PER_BIT/2 cycles.
  - rxs=0 at the end: clear the counter, go to DATA with bit index 0.
  - rxs=1 at the end: glitch. Return to IDLE with no output and no error.
- DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit) and shift right into the shift register, LSB first. After the 8th sample go to STOP, or to PARITY when the feature is enabled.
- STOP: sample after CLKS_PER_BIT cycles.
  - rxs=1: load rx_data from the shift register, set rx_valid, go to IDLE.
  - rxs=0: pulse frame_err for 1 cycle, leave rx_data and rx_valid unchanged, go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. Held-low lines generate exactly one frame_err.
- rx_busy = 1 in START, DATA, PARITY, STOP and BREAK.
- Handshake:
  - rx_valid is a level. It clears on the cycle after rx_ack=1 while rx_valid=1.
  - rx_ack while rx_valid=0 is ignored.
- Overrun: a good stop bit while rx_valid=1 and rx_ack=0 overwrites rx_data, keeps rx_valid=1 and pulses overrun_err.
- Simultaneous rx_ack and a good stop bit: the new byte is loaded, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times after the synchronised start edge.
- Counters saturate never. The bit counter resets at every bit boundary, and the bit index wraps only through state exit.
- Reset mid-frame aborts immediately. No partial byte or error is reported afterwards.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit at mid-bit.
  - A mismatch pulses parity_err for 1 cycle in the STOP-sample cycle, and the byte is not loaded (rx_valid unchanged).
  - A frame with both bad parity and a bad stop bit reports both pulses.
- Undefined: frames are 8N1, there is no PARITY state, and parity_err is tied to 0.

Test Plan:
- Reset held, serialIn=1 → all outputs 0. Release reset, idle 1000 cycles → rx_valid=0, rx_busy=0.
- Frame start 0, data bits 1,0,1,0,1,0,1,0, stop 1, each bit held 5208 cycles → rx_data=0x55 and rx_valid=1 about 49476 cycles after the start edge. Pulse rx_ack → rx_valid=0 next cycle.
- Back-to-back frames 0xAA then 0x08 with no ack → after the second frame rx_data=0x08, rx_valid=1, one overrun_err pulse. Same sequence with rx_ack coinciding with the second stop sample → no overrun_err.
- Low glitch of 1000 cycles on an idle line → return to IDLE, no rx_valid, no frame_err. Line held low 200000 cycles → exactly one frame_err, rx_data unchanged, rx_busy stays 1 until the line returns high.
- Assert reset during data bit 4 of a frame, release, then send 0x55 → only 0x55 is delivered; no error pulses.
- With UART_RX_PARITY_EN: 0x55 with parity bit 0 → rx_valid. Same byte with parity bit 1 → parity_err pulse and no rx_valid.
